// File: rtl/huffman_coder.sv
// -----------------------------------------------------------------------------
// huffman_coder
//   Builds a Huffman code for six symbols A1..A6 from their occurrence counts.
//   The counts are captured, the six leaves are ranked by count (descending,
//   lower index wins ties), then five merges of the two lowest-ranked nodes
//   grow the codewords one bit at a time from the LSB upwards. The finished
//   codes and masks are published with a one-cycle code_valid pulse. Latency
//   from the CNT_valid sample to code_valid is a fixed 7 cycles.
//
//   Optional feature (macro HUFFMAN_SUM_CHECK_EN): adds output sum_err, which is
//   high in the code_valid cycle when the six counts do not total 100.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   CNT_valid      one-cycle pulse; CNT1..CNT6 are valid (accepted in IDLE only)
//   CNT1..CNT6     8-bit occurrence counts of A1..A6
//   code_valid     one-cycle pulse; HC/M hold a new result
//   HC1..HC6       codeword of Ai, right-aligned, upper bits zero
//   M1..M6         mask of HCi, (1 << len_i) - 1
//   sum_err        (HUFFMAN_SUM_CHECK_EN only) count total != 100
// -----------------------------------------------------------------------------
module huffman_coder (
   input  logic       clk,
   input  logic       reset,
   input  logic       CNT_valid,
   input  logic [7:0] CNT1,
   input  logic [7:0] CNT2,
   input  logic [7:0] CNT3,
   input  logic [7:0] CNT4,
   input  logic [7:0] CNT5,
   input  logic [7:0] CNT6,
   output logic       code_valid,
   output logic [7:0] HC1,
   output logic [7:0] HC2,
   output logic [7:0] HC3,
   output logic [7:0] HC4,
   output logic [7:0] HC5,
   output logic [7:0] HC6,
   output logic [7:0] M1,
   output logic [7:0] M2,
   output logic [7:0] M3,
   output logic [7:0] M4,
   output logic [7:0] M5,
   output logic [7:0] M6
`ifdef HUFFMAN_SUM_CHECK_EN
   ,
   output logic       sum_err
`endif
);

   typedef enum logic [1:0] {IDLE, SORT, MERGE, DONE} state_e;

   // A node of the merge list: its total count and the set of member symbols.
   typedef struct packed {
      logic [7:0] cnt;
      logic [5:0] mem;
   } node_t;

   state_e     state_q, state_d;
   logic [7:0] cnt_q  [6], cnt_d  [6];
   node_t      node_q [6], node_d [6];   // position 0 = highest rank
   logic [7:0] code_q [6], code_d [6];
   logic [2:0] len_q  [6], len_d  [6];
   logic [2:0] mcnt_q, mcnt_d;           // merges already performed
   logic [7:0] hc_q   [6], hc_d   [6];
   logic [7:0] m_q    [6], m_d    [6];
   logic       valid_q, valid_d;

   logic [2:0] rank;    // sort position of one symbol
   logic [2:0] lo, up;  // list positions of the lowest and second-lowest node
   logic [2:0] ins;     // reinsertion position of the merged node
   node_t      merged;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      node_d  = node_q;
      code_d  = code_q;
      len_d   = len_q;
      mcnt_d  = mcnt_q;
      hc_d    = hc_q;
      m_d     = m_q;
      valid_d = 1'b0;
      rank    = '0;
      ins     = '0;
      lo      = 3'd5 - mcnt_q;
      up      = 3'd4 - mcnt_q;
      merged.cnt = node_q[lo].cnt + node_q[up].cnt;
      merged.mem = node_q[lo].mem | node_q[up].mem;

      case (state_q)
         IDLE: begin
            if (CNT_valid) begin
               cnt_d[0] = CNT1;
               cnt_d[1] = CNT2;
               cnt_d[2] = CNT3;
               cnt_d[3] = CNT4;
               cnt_d[4] = CNT5;
               cnt_d[5] = CNT6;
               for (int i = 0; i < 6; i++) begin
                  code_d[i] = '0;
                  len_d[i]  = '0;
               end
               state_d = SORT;
            end
         end

         SORT: begin
            // Rank = number of symbols that outrank this one; ranks form a
            // permutation, so each list slot is written exactly once.
            for (int i = 0; i < 6; i++) begin
               rank = '0;
               for (int j = 0; j < 6; j++) begin
                  if ((cnt_q[j] > cnt_q[i]) || ((cnt_q[j] == cnt_q[i]) && (j < i)))
                     rank = rank + 3'd1;
               end
               node_d[rank] = {cnt_q[i], 6'b1 << i};
            end
            mcnt_d  = '0;
            state_d = MERGE;
         end

         MERGE: begin
            // Lowest node gets bit 1 at position len; upper node gets bit 0,
            // which is already zero, so only its length advances.
            for (int s = 0; s < 6; s++) begin
               if (node_q[lo].mem[s])
                  code_d[s] = code_q[s] | (8'd1 << len_q[s]);
               if (merged.mem[s])
                  len_d[s] = len_q[s] + 3'd1;
            end
            // Surviving nodes 0..up-1 are sorted, so those strictly larger
            // than the merged count form a prefix; insert right after it.
            for (int k = 0; k < 6; k++) begin
               if ((3'(k) < up) && (node_q[k].cnt > merged.cnt))
                  ins = ins + 3'd1;
            end
            node_d[0] = (ins == 3'd0) ? merged : node_q[0];
            for (int k = 1; k < 6; k++) begin
               if (3'(k) < ins)       node_d[k] = node_q[k];
               else if (3'(k) == ins) node_d[k] = merged;
               else if (3'(k) <= up)  node_d[k] = node_q[k-1];
               else                   node_d[k] = '0;
            end
            if (mcnt_q == 3'd4) state_d = DONE;
            else                mcnt_d  = mcnt_q + 3'd1;
         end

         DONE: begin
            for (int i = 0; i < 6; i++) begin
               hc_d[i] = code_q[i];
               m_d[i]  = (8'd1 << len_q[i]) - 8'd1;
            end
            valid_d = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: these arrays are a handful of flops, not a RAM, so clearing
         // them in reset is cheap and keeps every internal node defined.
         state_q <= IDLE;
         cnt_q   <= '{default: '0};
         node_q  <= '{default: '0};
         code_q  <= '{default: '0};
         len_q   <= '{default: '0};
         mcnt_q  <= '0;
         hc_q    <= '{default: '0};
         m_q     <= '{default: '0};
         valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the
         // values present before the edge.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         node_q  <= node_d;
         code_q  <= code_d;
         len_q   <= len_d;
         mcnt_q  <= mcnt_d;
         hc_q    <= hc_d;
         m_q     <= m_d;
         valid_q <= valid_d;
      end
   end

   assign code_valid = valid_q;
   assign HC1 = hc_q[0];
   assign HC2 = hc_q[1];
   assign HC3 = hc_q[2];
   assign HC4 = hc_q[3];
   assign HC5 = hc_q[4];
   assign HC6 = hc_q[5];
   assign M1  = m_q[0];
   assign M2  = m_q[1];
   assign M3  = m_q[2];
   assign M4  = m_q[3];
   assign M5  = m_q[4];
   assign M6  = m_q[5];

`ifdef HUFFMAN_SUM_CHECK_EN
   logic [8:0] cnt_sum;
   logic       sum_err_q, sum_err_d;

   always_comb begin
      cnt_sum = 9'(cnt_q[0]) + 9'(cnt_q[1]) + 9'(cnt_q[2]) +
                9'(cnt_q[3]) + 9'(cnt_q[4]) + 9'(cnt_q[5]);
      sum_err_d = (state_q == DONE) && (cnt_sum != 9'd100);
   end

   always_ff @(posedge clk) begin
      if (reset) sum_err_q <= 1'b0;
      else       sum_err_q <= sum_err_d;
   end

   assign sum_err = sum_err_q;
`endif

endmodule

// File: doc/huffman_coder.md
HUFFMAN_CODER -- requirements
Module: huffman_coder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 CNT_valid  input  1  one-cycle pulse; CNT1..CNT6 are valid in this cycle.
REQ-005 CNT1..CNT6  input  8 each  occurrence counts of symbols A1..A6 (unsigned).
REQ-006 code_valid  output  1  one-cycle pulse; HC/M outputs hold the new result.
REQ-007 HC1..HC6  output  8 each  Huffman codeword of Ai, right-aligned (LSB = last bit), upper bits 0.
REQ-008 M1..M6  output  8 each  mask of HCi: (1 << len_i) - 1.

Function
REQ-009 The block SHALL implement FSM states IDLE, SORT, MERGE, DONE; reset -> IDLE.
REQ-010 IDLE: on CNT_valid=1, it SHALL capture CNT1..CNT6 and go to SORT; CNT_valid outside IDLE SHALL be ignored.
REQ-011 SORT SHALL order the six symbols by count, descending; among equal counts, the lower symbol index ranks higher (A1 above A2).
REQ-012 MERGE SHALL perform exactly 5 merges, each of the two lowest-ranked nodes: the upper (second-lowest) node appends bit 0 and the lowest node appends bit 1.
REQ-013 Each appended bit SHALL be placed at bit position len of every member symbol's codeword, after which len increments (new bit becomes the MSB of the code).
REQ-014 A merged node (sum of counts, 8-bit; the inputs total 100, so it cannot overflow) SHALL be reinserted above all existing nodes with an equal count.
REQ-015 After the 5th merge the FSM SHALL enter DONE, update HC1..HC6/M1..M6, pulse code_valid for one cycle, then return to IDLE.
REQ-016 Latency from the CNT_valid sample to code_valid SHALL be at most 20 cycles and identical for every input set.
REQ-017 HC/M SHALL hold their values until the next DONE.
REQ-018 Zero-count symbols SHALL be coded normally.
REQ-019 A code length above 5 cannot occur for 6 symbols; 8-bit fields SHALL be used regardless.

Reset
REQ-020 Reset SHALL force: state=IDLE, code_valid=0, HC1..HC6=0, M1..M6=0, and all internal nodes cleared.
REQ-021 Reset asserted mid-operation SHALL abandon the computation; no code_valid follows.
REQ-022 Reset SHALL take precedence over a simultaneous CNT_valid.

Configuration
REQ-023 With macro HUFFMAN_SUM_CHECK_EN defined, the block SHALL add output port sum_err (1 bit, reset 0).
REQ-024 With the macro, sum_err SHALL be asserted in the code_valid cycle exactly when CNT1+...+CNT6 (9-bit) != 100; codes SHALL still be produced.
REQ-025 Without the macro, the port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-026 Counts 40,20,15,10,10,5 -> HC=01,00,02,03,02,03; M=01,07,07,07,0F,0F (hex).
REQ-027 Counts 17,17,17,17,16,16 -> HC=02,03,00,01,02,03; M=03,03,07,07,07,07.
REQ-028 Counts 95,1,1,1,1,1 -> HC=00,05,06,07,08,09; M=01,07,07,07,0F,0F.
REQ-029 Scenario: CNT_valid with 40,20,15,10,10,5, then reset 3 cycles later, then no further input -> no code_valid; all outputs 0; a following CNT_valid yields the REQ-026 result.
REQ-030 Scenario: second CNT_valid (95,1,1,1,1,1) 2 cycles after the first (40,20,15,10,10,5) -> exactly one code_valid, carrying the REQ-026 result.
REQ-031 With HUFFMAN_SUM_CHECK_EN, counts 40,20,15,10,10,4 -> sum_err=1 with code_valid; counts from REQ-026 -> sum_err=0.
